axis_kx_packer: RTL and testbench
=================================

# axis_kx_packer

Front-end assembler that builds the wide packed weight+activation beat consumed by the matrix-vector multiplier's `s_axis_kx` stream. It accepts a weight matrix one row per beat on `s_axis_k` and the activation vector on `s_axis_x`, in any interleaving. Once R rows and one vector are collected, it emits a single `{k, x}` beat on `m_axis_kx`. It also flags row-count/`tlast` framing mismatches on the weight stream.

## Interface
- `R`, 8, matrix rows (weight rows per output beat); R ≥ 2.
- `C`, 8, matrix columns (elements per row and per vector).
- `W_K`, 8, weight element width.
- `W_X`, 8, activation element width.
- `clk`  in  1  clock; all logic on rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `s_axis_k_tvalid`  in  1  weight row valid.
- `s_axis_k_tready`  out  1  weight row ready.
- `s_axis_k_tdata`  in  C*W_K  one weight row; element c in bits [(c+1)*W_K-1 : c*W_K].
- `s_axis_k_tlast`  in  1  asserted by upstream on the last (R-th) row of a matrix.
- `s_axis_x_tvalid`  in  1  activation vector valid.
- `s_axis_x_tready`  out  1  activation vector ready.
- `s_axis_x_tdata`  in  C*W_X  activation vector.
- `m_axis_kx_tready`  in  1  downstream ready.
- `m_axis_kx_tvalid`  out  1  packed beat valid.
- `m_axis_kx_tdata`  out  R*C*W_K + C*W_X  packed beat `{k, x}`.
- `err_tlast`  out  1  sticky framing error.

## Operation
- **State**
  - `row_cnt`: 0..R, rows held.
  - `x_have`: vector held.
  - `full`: drives `m_axis_kx_tvalid`.
  - `k_buf`: R*C*W_K register.
  - `x_buf`: C*W_X register.
- **States**
  - COLLECT (`full` = 0) and FULL (`full` = 1).
  - COLLECT → FULL when, after this cycle's handshakes, `row_cnt` == R and `x_have` = 1.
  - FULL → COLLECT on `m_axis_kx_tvalid` && `m_axis_kx_tready`. That same cycle: `row_cnt` ← 0, `x_have` ← 0.
- **Readiness** (combinational from registers only; never from any input valid)
  - `s_axis_k_tready` = !`full` && (`row_cnt` < R).
  - `s_axis_x_tready` = !`full` && !`x_have`.
- **Weight accept** (k handshake): row written into `k_buf` slice [(`row_cnt`+1)*C*W_K-1 : `row_cnt`*C*W_K], then `row_cnt` incremented. The first accepted row is row 0, in the LSBs of k.
- **Vector accept** (x handshake): `x_buf` ← `s_axis_x_tdata`; `x_have` ← 1.
- **Simultaneous accepts**: k and x handshakes in the same cycle are both taken. If together they complete the set, `full` is set at that edge.
- **Output data**: `m_axis_kx_tdata` = {`k_buf`, `x_buf`}, i.e. k in the MSBs and x in the LSBs. It is stable while `m_axis_kx_tvalid` && !`m_axis_kx_tready`.
- **Framing check**: on each k handshake, if `s_axis_k_tlast` != (`row_cnt` == R-1), then `err_tlast` ← 1.
  - `err_tlast` is cleared only by reset.
  - Framing is governed by `row_cnt` alone; `tlast` never truncates or extends a matrix.
- **Arithmetic**: none; pure data movement. No width conversion, sign handling or reordering inside a row.

## Timing
- **Reset values**: `m_axis_kx_tvalid` 0, `m_axis_kx_tdata` 0, `err_tlast` 0, `s_axis_k_tready` 1, `s_axis_x_tready` 1. `row_cnt`, `x_have` and both buffers are 0.
- **Latency**: `m_axis_kx_tvalid` rises on the edge that completes the set. It is visible in the cycle after the final k/x handshake.
- **Throughput**: no new input is accepted while FULL, and both readies rise the cycle after the output handshake.
  - Minimum period is R+1 cycles per beat, with x overlapped with the k rows.
  - No bubble is required if downstream holds `tready` high.
- **Early vector**: x may arrive before, during or after the k rows. Once `x_have` = 1, `s_axis_x_tready` stays 0 until the beat is emitted.
- **Rows complete, no vector**: with `row_cnt` == R and no x, `s_axis_k_tready` = 0 and the block waits indefinitely.
- **Reset mid-frame**: asynchronous assertion clears all state immediately. Any partial matrix or vector is discarded, and a pending output beat is dropped.
- **AXIS compliance**: `m_axis_kx_tvalid` does not drop without a handshake.

## Test plan
Parameters for all scenarios: R=2, C=2, W_K=8, W_X=8; output width 48.
- **Basic pack**: k rows 0x0201 (tlast=0) then 0x0403 (tlast=1), x 0x0605 in the cycle of row 0, `m_axis_kx_tready`=1.
  - Expect `m_axis_kx_tvalid` high the cycle after row 1 with tdata 0x040302010605.
  - Readies return to 1 the next cycle; `err_tlast`=0.
- **Back-pressure**: as above with `m_axis_kx_tready`=0 for 5 cycles.
  - Expect tvalid and tdata held constant and both input readies 0 throughout.
  - Release → one handshake, then tvalid=0.
- **Late vector**: both k rows first, x 3 cycles later.
  - Expect `s_axis_k_tready`=0 after row 1 and tvalid rising the cycle after the x handshake.
- **Framing error**: send row 0 with tlast=1.
  - Expect `err_tlast`=1 from the next cycle, the packed beat still produced after row 1, and `err_tlast` remaining 1 across further correct frames.
- **Streaming**: 8 consecutive frames with all valids and `m_axis_kx_tready` held high.
  - Expect 8 beats, each with correct data, at a period of exactly 3 cycles.
- **Reset mid-frame**: accept row 0, pulse `rstn` low, then send a full new frame.
  - Expect the output to contain only the new frame's data and all reset values restored immediately at assertion.

Source files
------------

// File: rtl/axis_kx_packer_if.sv
// Stream bundle around the weight+activation packer: the weight-row input
// stream (k), the activation-vector input stream (x) and the packed output
// stream (kx).
//
// Handshake rule for every stream in this bundle: a beat transfers on a
// rising clk edge where tvalid && tready are both 1. A source that raises
// tvalid keeps it and its payload stable until the transfer. A sink derives
// tready from its own registers only and never from tvalid.
//
// Modport "slave" is the packer's view: it sinks k and x and sources kx.
// Modport "master" is the surrounding environment's view.
interface axis_kx_packer_if #(
    parameter int R   = 8,
    parameter int C   = 8,
    parameter int W_K = 8,
    parameter int W_X = 8
);
    logic                         s_axis_k_tvalid;
    logic                         s_axis_k_tready;
    logic [C*W_K-1:0]             s_axis_k_tdata;
    logic                         s_axis_k_tlast;

    logic                         s_axis_x_tvalid;
    logic                         s_axis_x_tready;
    logic [C*W_X-1:0]             s_axis_x_tdata;

    logic                         m_axis_kx_tready;
    logic                         m_axis_kx_tvalid;
    logic [R*C*W_K+C*W_X-1:0]     m_axis_kx_tdata;

    modport slave (
        input  s_axis_k_tvalid, s_axis_k_tdata, s_axis_k_tlast,
        input  s_axis_x_tvalid, s_axis_x_tdata,
        input  m_axis_kx_tready,
        output s_axis_k_tready, s_axis_x_tready,
        output m_axis_kx_tvalid, m_axis_kx_tdata
    );

    modport master (
        output s_axis_k_tvalid, s_axis_k_tdata, s_axis_k_tlast,
        output s_axis_x_tvalid, s_axis_x_tdata,
        output m_axis_kx_tready,
        input  s_axis_k_tready, s_axis_x_tready,
        input  m_axis_kx_tvalid, m_axis_kx_tdata
    );
endinterface

// File: rtl/axis_kx_packer.sv
// Weight+activation packer: collects R weight rows and one activation vector
// in any interleaving, then presents them as a single {k, x} beat. Rows land
// in k_buf in arrival order (row 0 in the LSBs). Also raises a sticky flag
// when the weight stream's tlast disagrees with the row count.
module axis_kx_packer #(
    parameter int R   = 8,
    parameter int C   = 8,
    parameter int W_K = 8,
    parameter int W_X = 8
) (
    input  logic              clk,
    input  logic              rstn,
    axis_kx_packer_if.slave   bus,
    output logic              err_tlast,
    output logic [0:0]        dbg_state
);
    localparam int ROW_W = C * W_K;
    localparam int K_W   = R * ROW_W;
    localparam int X_W   = C * W_X;
    localparam int CNT_W = $clog2(R + 1);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   row_cnt;
    logic               x_have;
    logic [K_W-1:0]     k_buf;
    logic [X_W-1:0]     x_buf;

    logic               full;
    logic               k_fire;
    logic               x_fire;
    logic               out_fire;
    logic [CNT_W-1:0]   rows_next;
    logic               x_next;
    logic               k_last_exp;

    assign full       = (state_q == FULL);
    assign dbg_state  = state_q;

    // Readiness depends on registers only, so no path from any valid to a ready.
    assign bus.s_axis_k_tready  = !full && (row_cnt < CNT_W'(R));
    assign bus.s_axis_x_tready  = !full && !x_have;
    assign bus.m_axis_kx_tvalid = full;
    assign bus.m_axis_kx_tdata  = {k_buf, x_buf};

    assign k_fire   = bus.s_axis_k_tvalid && bus.s_axis_k_tready;
    assign x_fire   = bus.s_axis_x_tvalid && bus.s_axis_x_tready;
    assign out_fire = full && bus.m_axis_kx_tready;

    // What the row count and vector flag will be after this cycle's accepts;
    // a k and an x landing together may complete the set in one edge.
    assign rows_next  = row_cnt + {{(CNT_W-1){1'b0}}, k_fire};
    assign x_next     = x_have || x_fire;
    assign k_last_exp = (row_cnt == CNT_W'(R - 1));

    // Next state: fill until every row and the vector are held, then hold the
    // beat until downstream takes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if ((rows_next == CNT_W'(R)) && x_next) state_d = FULL;
            FULL:    if (bus.m_axis_kx_tready) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= COLLECT;
        else       state_q <= state_d;
    end

    // Row counter and vector flag: advance on accepts, clear on output handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_cnt <= '0;
            x_have  <= 1'b0;
        end else if (out_fire) begin
            row_cnt <= '0;
            x_have  <= 1'b0;
        end else begin
            if (k_fire) row_cnt <= row_cnt + CNT_W'(1);
            if (x_fire) x_have  <= 1'b1;
        end
    end

    // Data buffers: each accepted row goes to the slot indexed by row_cnt.
    // They are not cleared after a beat; the next frame overwrites them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k_buf <= '0;
            x_buf <= '0;
        end else begin
            for (int r = 0; r < R; r++) begin
                if (k_fire && (row_cnt == CNT_W'(r)))
                    k_buf[r*ROW_W +: ROW_W] <= bus.s_axis_k_tdata;
            end
            if (x_fire) x_buf <= bus.s_axis_x_tdata;
        end
    end

    // Sticky framing flag: tlast must mark exactly the R-th row of each matrix.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                           err_tlast <= 1'b0;
        else if (k_fire && (bus.s_axis_k_tlast != k_last_exp)) err_tlast <= 1'b1;
    end
endmodule

// File: tb/tb_axis_kx_packer.sv
// Bench for axis_kx_packer with R=2, C=2, 8-bit elements (48-bit beat).
// A frame-level reference model (queues of accepted rows, the held vector and
// the list of pending output beats) predicts every output cycle by cycle.
module tb_axis_kx_packer;
    localparam int R     = 2;
    localparam int C     = 2;
    localparam int W_K   = 8;
    localparam int W_X   = 8;
    localparam int ROW_W = C * W_K;
    localparam int X_W   = C * W_X;
    localparam int OUT_W = R * ROW_W + X_W;

    logic clk;
    logic rstn;
    logic err_tlast;
    logic [0:0] dbg_state;

    axis_kx_packer_if #(.R(R), .C(C), .W_K(W_K), .W_X(W_X)) bus ();

    axis_kx_packer #(.R(R), .C(C), .W_K(W_K), .W_X(W_X)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .err_tlast (err_tlast),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    logic [OUT_W-1:0] exp_q[$];     // beats owed to downstream, oldest first
    logic [ROW_W-1:0] k_rows[$];    // rows accepted for the frame being built
    logic [X_W-1:0]   x_val;
    bit               x_held;
    bit               exp_err;
    int               n_vec;
    int               n_bad;
    int               beats_out;
    int               cycle;
    int               last_beat_cycle;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        k_rows.delete();
        x_val  = '0;
        x_held = 0;
        exp_err = 0;
    endtask

    // One clock cycle: check outputs against the model, drive inputs, then
    // advance the model by the transfers the model says will happen.
    task automatic step(input logic kv, input logic [ROW_W-1:0] kd, input logic kl,
                        input logic xv, input logic [X_W-1:0] xd, input logic rdy);
        bit pend;
        bit k_rdy;
        bit x_rdy;
        logic [OUT_W-1:0] b;
        @(negedge clk);
        cycle++;
        pend  = (exp_q.size() != 0);
        k_rdy = !pend && (k_rows.size() < R);
        x_rdy = !pend && !x_held;
        check("kx_tvalid", bus.m_axis_kx_tvalid, pend);
        if (pend) check("kx_tdata", bus.m_axis_kx_tdata, exp_q[0]);
        check("k_tready", bus.s_axis_k_tready, k_rdy);
        check("x_tready", bus.s_axis_x_tready, x_rdy);
        check("err_tlast", err_tlast, exp_err);
        check("dbg_state", dbg_state, pend);

        bus.s_axis_k_tvalid  = kv;
        bus.s_axis_k_tdata   = kd;
        bus.s_axis_k_tlast   = kl;
        bus.s_axis_x_tvalid  = xv;
        bus.s_axis_x_tdata   = xd;
        bus.m_axis_kx_tready = rdy;

        if (pend && rdy) begin
            void'(exp_q.pop_front());
            k_rows.delete();
            x_held = 0;
            beats_out++;
            last_beat_cycle = cycle;
        end
        if (kv && k_rdy) begin
            if (kl != (k_rows.size() == R - 1)) exp_err = 1;
            k_rows.push_back(kd);
        end
        if (xv && x_rdy) begin
            x_val  = xd;
            x_held = 1;
        end
        if (!pend && k_rows.size() == R && x_held) begin
            b = '0;
            b[X_W-1:0] = x_val;
            for (int i = 0; i < R; i++) b[X_W + i*ROW_W +: ROW_W] = k_rows[i];
            exp_q.push_back(b);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.s_axis_k_tvalid  = 0;
        bus.s_axis_x_tvalid  = 0;
        bus.m_axis_kx_tready = 0;
        #2 rstn = 0;
        #1;
        check("rst_tvalid", bus.m_axis_kx_tvalid, 0);
        check("rst_tdata", bus.m_axis_kx_tdata, 0);
        check("rst_err", err_tlast, 0);
        check("rst_k_tready", bus.s_axis_k_tready, 1);
        check("rst_x_tready", bus.s_axis_x_tready, 1);
        model_clear();
        repeat (2) @(negedge clk);
        rstn = 1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int start_beats;
        rstn = 0;
        bus.s_axis_k_tvalid = 0; bus.s_axis_k_tdata = '0; bus.s_axis_k_tlast = 0;
        bus.s_axis_x_tvalid = 0; bus.s_axis_x_tdata = '0; bus.m_axis_kx_tready = 0;
        n_vec = 0; n_bad = 0; beats_out = 0; cycle = 0; last_beat_cycle = 0;
        model_clear();
        do_reset();

        // basic pack: x alongside row 0
        step(1, 16'h0201, 0, 1, 16'h0605, 1);
        step(1, 16'h0403, 1, 0, '0, 1);
        @(posedge clk); #1;
        check("basic_beat", bus.m_axis_kx_tdata, 48'h040302010605);
        idle(2);

        // back-pressure for 5 cycles, then release
        step(1, 16'h1211, 0, 1, 16'h1615, 0);
        step(1, 16'h1413, 1, 0, '0, 0);
        for (int i = 0; i < 5; i++) step(0, '0, 0, 0, '0, 0);
        idle(2);

        // late vector: rows first, x three cycles later
        step(1, 16'h2221, 0, 0, '0, 1);
        step(1, 16'h2423, 1, 0, '0, 1);
        for (int i = 0; i < 3; i++) step(1, 16'hdead, 0, 0, '0, 1);
        step(0, '0, 0, 1, 16'h2625, 1);
        idle(2);

        // framing error on row 0, then further good frames keep the flag
        step(1, 16'h3231, 1, 1, 16'h3635, 1);
        step(1, 16'h3433, 1, 0, '0, 1);
        idle(1);
        step(1, 16'h4241, 0, 1, 16'h4645, 1);
        step(1, 16'h4443, 1, 0, '0, 1);
        idle(2);

        // streaming: everything valid, downstream always ready
        start_beats = beats_out;
        for (int i = 0; i < 3 * 8; i++)
            step(1, 16'($urandom), (k_rows.size() == R - 1), 1, 16'($urandom), 1);
        idle(2);
        check("stream_beats", beats_out - start_beats, 8);
        check("stream_last_cycle", last_beat_cycle, cycle - 2);

        // reset mid-frame: partial frame is discarded
        step(1, 16'h5251, 0, 1, 16'h5655, 1);
        do_reset();
        step(1, 16'h6261, 0, 0, '0, 1);
        step(1, 16'h6463, 1, 1, 16'h6665, 1);
        @(posedge clk); #1;
        check("rst_new_beat", bus.m_axis_kx_tdata, 48'h646362616665);
        idle(2);

        // random traffic with occasional tlast mistakes
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, 16'($urandom),
                 (k_rows.size() == R - 1) ^ ($urandom_range(0, 29) == 0),
                 $urandom_range(0, 2) != 0, 16'($urandom),
                 $urandom_range(0, 3) != 0);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
